fetch_stage: RTL and testbench

Instruction fetch stage directly downstream of the program counter.
- Consumes pc_out each cycle and reads a synchronous instruction memory.
- Presents a registered instruction word, its address and a valid flag to decode.
- Flushes on a taken branch, detects the halt word, raises done, and counts run cycles.
- Program is loaded through a write port while the core is not running.

---
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: synchronous instruction memory, fetch/decode register, halt detection and run-cycle counter.
// Optional macro FETCH_FLUSH_COUNT_EN adds a saturating flush_count output.
module fetch_stage #(
  parameter int unsigned instr_width = 9,
  parameter int unsigned data_width  = 9,
  parameter logic [data_width-1:0] halt_word = data_width'(9'h1FF),
  parameter int unsigned cnt_width   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [instr_width-1:0] pc_in,
  input  logic                   taken,
  input  logic                   stall,
  input  logic                   load_en,
  input  logic [instr_width-1:0] load_addr,
  input  logic [data_width-1:0]  load_data,
  output logic [data_width-1:0]  instr_out,
  output logic [instr_width-1:0] instr_pc,
  output logic                   instr_valid,
  output logic                   done,
  output logic [cnt_width-1:0]   cycle_count
`ifdef FETCH_FLUSH_COUNT_EN
  ,
  output logic [7:0]             flush_count
`endif
);

  localparam int unsigned depth = 1 << instr_width;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t                  state;
  logic [data_width-1:0]   mem [depth];
  logic [data_width-1:0]   rd_word;

  // Read is sampled into instr_out on the edge, so a colliding write is seen only afterwards.
  assign rd_word = mem[pc_in];

  // Program load is only accepted while the core is not running.
  always_ff @(posedge clk) begin
    if (load_en && state != RUN) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
`ifdef FETCH_FLUSH_COUNT_EN
      flush_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
`ifdef FETCH_FLUSH_COUNT_EN
            flush_count <= '0;
`endif
          end
        end
        RUN: begin
          if (start) begin
            instr_valid <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
`ifdef FETCH_FLUSH_COUNT_EN
            flush_count <= '0;
`endif
          end else begin
            if (cycle_count != '1) cycle_count <= cycle_count + cnt_width'(1);
            // Taken branch squashes the fetch even while stalled.
            if (taken) begin
              instr_out   <= '0;
              instr_pc    <= pc_in;
              instr_valid <= 1'b0;
`ifdef FETCH_FLUSH_COUNT_EN
              if (flush_count != 8'hFF) flush_count <= flush_count + 8'd1;
`endif
            end else if (!stall) begin
              instr_out   <= rd_word;
              instr_pc    <= pc_in;
              instr_valid <= 1'b1;
              if (rd_word == halt_word) state <= HALT;
            end
          end
        end
        HALT: begin
          if (start) begin
            state       <= RUN;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
`ifdef FETCH_FLUSH_COUNT_EN
            flush_count <= '0;
`endif
          end else begin
            instr_valid <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (flush counter checks built when FETCH_FLUSH_COUNT_EN is defined).
module tb_fetch_stage;

  logic       clk;
  logic       rst;
  logic       start;
  logic [8:0] pc_in;
  logic       taken;
  logic       stall;
  logic       load_en;
  logic [8:0] load_addr;
  logic [8:0] load_data;
  logic [8:0] instr_out;
  logic [8:0] instr_pc;
  logic       instr_valid;
  logic       done;
  logic [15:0] cycle_count;
`ifdef FETCH_FLUSH_COUNT_EN
  logic [7:0] flush_count;
`endif

  int n_checks;
  int n_pass;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc_in       (pc_in),
    .taken       (taken),
    .stall       (stall),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .done        (done),
    .cycle_count (cycle_count)
`ifdef FETCH_FLUSH_COUNT_EN
    ,
    .flush_count (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [8:0] a, input logic [8:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; pc_in = '0; taken = 1'b0; stall = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    #12;
    check("rst_instr", instr_out, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cycle_count, 0);
    rst = 1'b0;

    load(9'd0, 9'h010);
    load(9'd1, 9'h011);
    load(9'd2, 9'h012);
    load(9'd3, 9'h1FF);
    check("idle_no_valid", instr_valid, 0);

    // Basic program run through to halt
    start = 1'b1; step(); start = 1'b0;
    check("start_valid", instr_valid, 0);
    check("start_cnt", cycle_count, 0);
    pc_in = 9'd0; step();
    check("e1_instr", instr_out, 9'h010);
    check("e1_valid", instr_valid, 1);
    check("e1_pc", instr_pc, 0);
    check("e1_cnt", cycle_count, 1);
    pc_in = 9'd1; step();
    check("e2_instr", instr_out, 9'h011);
    pc_in = 9'd2; step();
    check("e3_instr", instr_out, 9'h012);
    check("e3_pc", instr_pc, 2);
    pc_in = 9'd3; step();
    check("e4_instr", instr_out, 9'h1FF);
    check("e4_valid", instr_valid, 1);
    check("e4_done", done, 0);
    pc_in = 9'd0; step();
    check("e5_done", done, 1);
    check("e5_valid", instr_valid, 0);
    check("e5_instr", instr_out, 9'h1FF);
    check("e5_cnt", cycle_count, 4);
    step();
    check("halt_cnt_hold", cycle_count, 4);
    check("halt_pc_hold", instr_pc, 3);

    // Restart from HALT, then taken-branch flush
    start = 1'b1; step(); start = 1'b0;
    check("restart_done", done, 0);
    check("restart_cnt", cycle_count, 0);
    pc_in = 9'd5; taken = 1'b1; step(); taken = 1'b0;
    check("flush_instr", instr_out, 0);
    check("flush_valid", instr_valid, 0);
    check("flush_pc", instr_pc, 5);
    pc_in = 9'd2; step();
    check("post_flush_instr", instr_out, 9'h012);
    check("post_flush_valid", instr_valid, 1);

    // Stall holds outputs while the counter keeps running
    pc_in = 9'd1; step();
    check("pre_stall_cnt", cycle_count, 3);
    stall = 1'b1; pc_in = 9'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", instr_out, 9'h011);
      check("stall_valid", instr_valid, 1);
      check("stall_pc", instr_pc, 1);
    end
    check("stall_cnt", cycle_count, 6);
    taken = 1'b1; pc_in = 9'd7; step(); taken = 1'b0; stall = 1'b0;
    check("taken_stall_valid", instr_valid, 0);
    check("taken_stall_instr", instr_out, 0);
    check("taken_stall_pc", instr_pc, 7);
    check("taken_stall_cnt", cycle_count, 7);

    // Load ignored while running
    pc_in = 9'd0; load_en = 1'b1; load_addr = 9'd1; load_data = 9'h0AA; step(); load_en = 1'b0;
    check("run_load_fetch", instr_out, 9'h010);
    pc_in = 9'd1; step();
    check("run_load_ignored", instr_out, 9'h011);

    // Load accepted in HALT, visible after restart
    pc_in = 9'd3; step();
    step();
    check("halt2_done", done, 1);
    load(9'd1, 9'h0AA);
    start = 1'b1; step(); start = 1'b0;
    pc_in = 9'd1; step();
    check("halt_load_fetch", instr_out, 9'h0AA);
    check("halt_load_valid", instr_valid, 1);

    // Asynchronous reset mid-run
    #1 rst = 1'b1;
    #1;
    check("async_rst_instr", instr_out, 0);
    check("async_rst_valid", instr_valid, 0);
    check("async_rst_pc", instr_pc, 0);
    check("async_rst_cnt", cycle_count, 0);
    #1 rst = 1'b0;
    pc_in = 9'd0; step(); step();
    check("idle_after_rst_valid", instr_valid, 0);
    check("idle_after_rst_cnt", cycle_count, 0);
    start = 1'b1; step(); start = 1'b0;
    step();
    check("rerun_instr", instr_out, 9'h010);
    check("rerun_valid", instr_valid, 1);

`ifdef FETCH_FLUSH_COUNT_EN
    start = 1'b1; step(); start = 1'b0;
    check("fc_start", flush_count, 0);
    taken = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("fc_three", flush_count, 3);
    for (int i = 0; i < 297; i++) step();
    taken = 1'b0;
    check("fc_sat", flush_count, 8'hFF);
    check("fc_cnt", cycle_count, 300);
    start = 1'b1; step(); start = 1'b0;
    check("fc_clear", flush_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
